// File: rtl/mc_ctrl_if.sv
// Control bundle between mc_ctrl_fsm and the datapath/memory.
// master = control unit, slave = datapath side.
interface mc_ctrl_if #(
   parameter int D_WIDTH = 32
);
   logic [D_WIDTH-1:0] instr;
   logic               eq;
   logic               mem_ready;
   logic               mem_req;
   logic               irwrite;
   logic               pcwrite;
   logic               pcsrc;
   logic               alusrc;
   logic [2:0]         aluctrl;
   logic [1:0]         immsrc;
   logic               regwrite;
   logic               memwrite;
   logic               resultsrc;
   logic               illegal;

   modport master (
      input  instr, eq, mem_ready,
      output mem_req, irwrite, pcwrite, pcsrc,
      output alusrc, aluctrl, immsrc,
      output regwrite, memwrite, resultsrc,
      output illegal
   );

   modport slave (
      output instr, eq, mem_ready,
      input  mem_req, irwrite, pcwrite, pcsrc,
      input  alusrc, aluctrl, immsrc,
      input  regwrite, memwrite, resultsrc,
      input  illegal
   );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the reduced RISC-V core.
// MC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt and set sticky illegal.
module mc_ctrl_fsm #(
   parameter int D_WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   mc_ctrl_if.master  bus
);

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEM       = 3'd3,
      WRITEBACK = 3'd4
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ,
      HALT      = 3'd5
`endif
   } state_t;

   state_t st, nxt;

   logic [D_WIDTH-1:0] ir;
   logic [6:0]         op;
   logic [2:0]         f3;
   logic [6:0]         f7;
   logic               unused_ir;

   assign ir        = bus.instr;
   assign op        = ir[6:0];
   assign f3        = ir[14:12];
   assign f7        = ir[31:25];
   assign unused_ir = ^{ir[24:15], ir[11:7]};

   logic       f7z, f7s, r_ok;
   logic [2:0] r_alu;

   assign f7z = (f7 == 7'b0000000);
   assign f7s = (f7 == 7'b0100000);

   always_comb begin
      r_ok  = 1'b1;
      r_alu = 3'b000;
      unique case (1'b1)
         f7z && f3 == 3'b000: r_alu = 3'b000;
         f7s && f3 == 3'b000: r_alu = 3'b001;
         f7z && f3 == 3'b111: r_alu = 3'b010;
         f7z && f3 == 3'b110: r_alu = 3'b011;
         f7z && f3 == 3'b010: r_alu = 3'b101;
         default:             r_ok  = 1'b0;
      endcase
   end

   logic is_r, is_addi, is_lw, is_sw;
   logic is_br, legal, taken;

   assign is_r    = (op == 7'b0110011) && r_ok;
   assign is_addi = (op == 7'b0010011)
                 && (f3 == 3'b000);
   assign is_lw   = (op == 7'b0000011)
                 && (f3 == 3'b010);
   assign is_sw   = (op == 7'b0100011)
                 && (f3 == 3'b010);
   assign is_br   = (op == 7'b1100011)
                 && (f3[2:1] == 2'b00);
   assign legal   = is_r | is_addi | is_lw
                  | is_sw | is_br;
   // f3[0] distinguishes bne from beq
   assign taken   = f3[0] ? !bus.eq : bus.eq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= FETCH;
      else        st <= nxt;
   end

   // Everything is gated by rst_n so reset silences all enables at once.
   always_comb begin
      nxt           = st;
      bus.mem_req   = 1'b0;
      bus.irwrite   = 1'b0;
      bus.pcwrite   = 1'b0;
      bus.pcsrc     = 1'b0;
      bus.alusrc    = 1'b0;
      bus.aluctrl   = 3'b000;
      bus.immsrc    = 2'b00;
      bus.regwrite  = 1'b0;
      bus.memwrite  = 1'b0;
      bus.resultsrc = 1'b0;
      if (rst_n) begin
         unique case (st)
            FETCH: begin
               bus.mem_req = 1'b1;
               if (bus.mem_ready) begin
                  bus.irwrite = 1'b1;
                  bus.pcwrite = 1'b1;
                  nxt         = DECODE;
               end
            end
            DECODE: begin
               if (is_sw)      bus.immsrc = 2'b01;
               else if (is_br) bus.immsrc = 2'b10;
               if (legal) nxt = EXECUTE;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               else       nxt = HALT;
`else
               else       nxt = FETCH;
`endif
            end
            EXECUTE: begin
               unique case (1'b1)
                  is_r: begin
                     bus.aluctrl = r_alu;
                     nxt         = WRITEBACK;
                  end
                  is_addi: begin
                     bus.alusrc = 1'b1;
                     nxt        = WRITEBACK;
                  end
                  is_lw || is_sw: begin
                     bus.alusrc = 1'b1;
                     nxt        = MEM;
                  end
                  is_br: begin
                     bus.aluctrl = 3'b001;
                     bus.pcwrite = taken;
                     bus.pcsrc   = taken;
                     nxt         = FETCH;
                  end
                  default: nxt = FETCH;
               endcase
            end
            MEM: begin
               bus.mem_req  = 1'b1;
               bus.memwrite = is_sw;
               if (bus.mem_ready)
                  nxt = is_lw ? WRITEBACK : FETCH;
            end
            WRITEBACK: begin
               bus.regwrite  = 1'b1;
               bus.resultsrc = is_lw;
               nxt           = FETCH;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            HALT: nxt = HALT;
`endif
            default: nxt = FETCH;
         endcase
      end
   end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic ill_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ill_q <= 1'b0;
      else if (st == DECODE && !legal)
         ill_q <= 1'b1;
   end

   assign bus.illegal = ill_q;
`else
   assign bus.illegal = 1'b0;
`endif

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control unit for the reduced RISC-V core. It decodes the latched instruction word and sequences each instruction through fetch, decode, execute, memory and writeback. It drives the ALU control interface (`alusrc`, `aluctrl`) and consumes the ALU's `eq` result to resolve branches. It sits between the instruction register and the datapath, and its state register is the only sequential state in the core's control path.

## Interface
Parameters:
- `D_WIDTH`, 32, instruction/data word width; only 32 is supported.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  D_WIDTH  instruction register contents; stable from the DECODE state until the next FETCH.
- `eq`  in  1  ALU equality flag (`aluop1 == aluop2`).
- `mem_ready`  in  1  memory handshake; completes the current fetch or data access.
- `mem_req`  out  1  memory request; high in FETCH and MEM.
- `irwrite`  out  1  load the instruction register.
- `pcwrite`  out  1  PC update enable.
- `pcsrc`  out  1  PC source: 0 = PC+4, 1 = branch target (PC+imm).
- `alusrc`  out  1  ALU operand 2 select: 0 = register, 1 = immediate.
- `aluctrl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- `immsrc`  out  2  immediate format: 00 I, 01 S, 10 B.
- `regwrite`  out  1  register-file write enable.
- `memwrite`  out  1  data-memory write (store).
- `resultsrc`  out  1  writeback source: 0 = ALU result, 1 = memory read data.
- `illegal`  out  1  sticky illegal-opcode flag; functional only with the macro described under Configuration.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT. The state register is 3 bits.
- Supported opcodes:
  - 0110011 R-type: `funct3`/`funct7[5]` select add, sub, and, or, slt.
  - 0010011 addi.
  - 0000011 lw.
  - 0100011 sw.
  - 1100011 beq/bne: `funct3` 000 is beq, 001 is bne.
- Any other opcode is illegal, as is any unsupported `funct3`/`funct7` combination.
- FETCH:
  - `mem_req`=1.
  - When `mem_ready`=1: `irwrite`=1, `pcwrite`=1, `pcsrc`=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: drive `immsrc` for the latched opcode.
  - Go to EXECUTE for legal instructions.
  - Go to FETCH for illegal instructions, or to HALT when the macro is defined.
- EXECUTE:
  - R-type: `alusrc`=0, `aluctrl` per function, then WRITEBACK.
  - addi: `alusrc`=1, `aluctrl`=000, then WRITEBACK.
  - lw/sw: `alusrc`=1, `aluctrl`=000 (address), then MEM.
  - Branch: `alusrc`=0, `aluctrl`=001.
    - Taken when (beq and `eq`) or (bne and !`eq`).
    - If taken: `pcwrite`=1, `pcsrc`=1.
    - Then FETCH.
- MEM:
  - `mem_req`=1; for sw, `memwrite`=1 for as long as the state is held.
  - Stay while `mem_ready`=0.
  - On `mem_ready`=1: lw goes to WRITEBACK, sw goes to FETCH.
- WRITEBACK: `regwrite`=1 for exactly one cycle; `resultsrc`=1 for lw, 0 otherwise; then FETCH.
- HALT: all enables 0; held until reset.
- Outputs are combinational from state, `instr`, `eq` and `mem_ready`. In every state, any output not listed above is 0; `aluctrl` defaults to 000.

## Timing
- Reset:
  - `rst_n` low forces state to FETCH asynchronously.
  - All outputs are 0 while in reset; `mem_req` rises to 1 once FETCH is entered.
  - `illegal` clears to 0.
- Reset asserted mid-instruction abandons it: no partial `regwrite`, `memwrite` or `pcwrite` may be issued after `rst_n` falls.
- Cycles per instruction with `mem_ready` tied high:
  - R-type/addi: 4.
  - lw: 5.
  - sw: 4.
  - branch: 3.
  - illegal without the macro: 2.
- Each cycle `mem_ready` is low in FETCH or MEM adds exactly one cycle.
- `mem_ready` is ignored outside FETCH and MEM.
- `pcwrite` pulses at most once per state visit, and never in DECODE, MEM or WRITEBACK.

## Configuration
- Macro: `MC_CTRL_ILLEGAL_TRAP_EN`.
- Defined:
  - An illegal instruction in DECODE goes to HALT and sets `illegal`=1.
  - `illegal` stays set until `rst_n` is asserted.
- Not defined:
  - An illegal instruction is a 2-cycle NOP: DECODE goes to FETCH with no writes.
  - `illegal` is tied to 0 and the HALT state is not compiled.

## Test plan
- Reset mid-EXECUTE of `add x1,x2,x3` (0x003100B3) -> state FETCH and all enables 0 immediately; no `regwrite` pulse afterwards.
- `mem_ready`=1, `addi x1,x0,5` (0x00500093) -> `irwrite`/`pcwrite` in cycle 0; `alusrc`=1 with `aluctrl`=000 in cycle 2; `regwrite`=1, `resultsrc`=0 in cycle 3; back to FETCH in cycle 4.
- `sub x3,x1,x2` (0x402081B3) -> `aluctrl`=001, `alusrc`=0 in EXECUTE.
- `lw x5,0(x6)` (0x00032283) with `mem_ready` low for 3 cycles in MEM -> `mem_req` held for 4 cycles; `regwrite`=1, `resultsrc`=1 one cycle after `mem_ready`; total 8 cycles.
- `bne x1,x2,-8` (0xFE209CE3):
  - With `eq`=0 -> `pcwrite`=1, `pcsrc`=1 in EXECUTE.
  - With `eq`=1 -> `pcwrite`=0.
- Opcode 0x0000007F:
  - Without the macro -> FETCH two cycles later, no writes.
  - With the macro -> HALT, `illegal`=1 held for 20+ cycles until `rst_n`=0.
